// File: rtl/adc_clk_pkg.sv
// Shared definitions for the ADC clock health monitor: FSM encoding,
// default configuration constants and the window limit compare.
package adc_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 1000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_LO_LIMIT    = 120;
  localparam int DEF_HI_LIMIT    = 130;

  // Inclusive range test; an inverted range (lo > hi) can never pass,
  // so a misconfigured monitor reports every window as a fault.
  function automatic logic in_window(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/adc_clk_edge_cnt.sv
// One channel of the monitor: synchronises an asynchronous divided ADC
// clock toggle, detects its rising edges and counts them with saturation.
// count_next exposes the value the counter takes at the coming edge so the
// top level can capture a window that includes its final cycle.
module adc_clk_edge_cnt
  import adc_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             tgl,
  output logic [CNT_W-1:0] count_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_r;
  logic             sync2_r;
  logic             sync3_r;
  logic             edge_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  assign edge_s     = sync2_r & ~sync3_r;
  assign count_next = cnt_nxt_s;

  // Two-flop synchroniser followed by the edge-detect history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= tgl;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Next count: clear, reload with the current edge, or saturating increment.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (load) begin
      cnt_nxt_s = {{(CNT_W-1){1'b0}}, edge_s};
    end else if (edge_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Edge counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/adc_clk_monitor.sv
// Multi-channel ADC clock health monitor. Counts rising edges of each
// divided ADC clock over a fixed gate window and reports per-channel rate,
// in-range status and a sticky lost/out-of-range flag.
// Results are captured at the edge that ends the last gate cycle, so they
// are visible (with freq_valid) during the LATCH cycle itself.
module adc_clk_monitor
  import adc_clk_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LO_LIMIT    = DEF_LO_LIMIT,
  parameter int HI_LIMIT    = DEF_HI_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clr_lost,
  input  logic [NUM_CH-1:0]       adc_clk_tgl,
  output logic [NUM_CH*CNT_W-1:0] freq_count,
  output logic                    freq_valid,
  output logic [NUM_CH-1:0]       clk_ok,
  output logic [NUM_CH-1:0]       clk_lost
);

  localparam int              GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [GATE_W-1:0]         gate_cnt_r;
  logic                      clr_s;
  logic                      load_s;
  logic                      last_gate_s;
  logic [NUM_CH*CNT_W-1:0]   cnt_nxt_s;
  logic [NUM_CH-1:0]         in_range_s;
  logic [NUM_CH-1:0]         lost_nxt_s;
  logic [NUM_CH*CNT_W-1:0]   freq_count_r;
  logic                      freq_valid_r;
  logic [NUM_CH-1:0]         clk_ok_r;
  logic [NUM_CH-1:0]         clk_lost_r;

  assign freq_count = freq_count_r;
  assign freq_valid = freq_valid_r;
  assign clk_ok     = clk_ok_r;
  assign clk_lost   = clk_lost_r;

  // Per-channel synchroniser/counter and limit compare.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_clk_edge_cnt #(
      .CNT_W(CNT_W)
    ) u_edge_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_s),
      .load      (load_s),
      .tgl       (adc_clk_tgl[i]),
      .count_next(cnt_nxt_s[i*CNT_W +: CNT_W])
    );
    assign in_range_s[i] = in_window(32'(cnt_nxt_s[i*CNT_W +: CNT_W]),
                                     32'(LO_LIMIT), 32'(HI_LIMIT));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and counter controls; dropping enable mid-gate aborts the window.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    load_s      = 1'b0;
    last_gate_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s = 1'b1;
        if (enable) begin
          state_nxt_s = ST_GATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
          clr_s       = 1'b1;
        end else if (gate_cnt_r == GATE_LAST) begin
          state_nxt_s = ST_LATCH;
          last_gate_s = 1'b1;
        end else begin
          state_nxt_s = ST_GATE;
        end
      end
      ST_LATCH: begin
        load_s = 1'b1;
        if (enable) begin
          state_nxt_s = ST_GATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        clr_s       = 1'b1;
      end
    endcase
  end

  // Gate counter: runs only while gating, zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt_r <= {GATE_W{1'b0}};
    end else if ((state_r == ST_GATE) && enable && !last_gate_s) begin
      gate_cnt_r <= gate_cnt_r + GATE_ONE;
    end else begin
      gate_cnt_r <= {GATE_W{1'b0}};
    end
  end

  // Sticky fault update. A fresh fault always survives a coincident clear;
  // a clear during LATCH spares the channels that window just reported bad.
  always_comb begin
    lost_nxt_s = clk_lost_r;
    if (last_gate_s) begin
      lost_nxt_s = (clr_lost ? {NUM_CH{1'b0}} : clk_lost_r) | ~in_range_s;
    end else if (clr_lost && (state_r == ST_LATCH)) begin
      lost_nxt_s = clk_lost_r & ~clk_ok_r;
    end else if (clr_lost) begin
      lost_nxt_s = {NUM_CH{1'b0}};
    end else begin
      lost_nxt_s = clk_lost_r;
    end
  end

  // Registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_count_r <= {(NUM_CH*CNT_W){1'b0}};
      freq_valid_r <= 1'b0;
      clk_ok_r     <= {NUM_CH{1'b0}};
      clk_lost_r   <= {NUM_CH{1'b0}};
    end else begin
      freq_valid_r <= last_gate_s;
      clk_lost_r   <= lost_nxt_s;
      if (last_gate_s) begin
        freq_count_r <= cnt_nxt_s;
        clk_ok_r     <= in_range_s;
      end else begin
        freq_count_r <= freq_count_r;
        clk_ok_r     <= clk_ok_r;
      end
    end
  end

endmodule

// File: tb/tb_adc_clk_monitor.sv
// Directed bench for adc_clk_monitor: default-configured instance plus a
// 6-bit-count instance (saturation) and an inverted-limit instance.
// A 1001-cycle window of a period-8 toggle holds 125 or 126 rising edges
// depending on phase, so nominal channels accept either value.
module tb_adc_clk_monitor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clr_lost;
  logic [3:0]  tgl;
  logic [63:0] freq_count;
  logic        freq_valid;
  logic [3:0]  clk_ok;
  logic [3:0]  clk_lost;

  logic        sat_tgl;
  logic [5:0]  sat_count;
  logic        sat_valid;
  logic        sat_ok;
  logic        sat_lost;

  logic        cfg_tgl;
  logic [15:0] cfg_count;
  logic        cfg_valid;
  logic        cfg_ok;
  logic        cfg_lost;

  int per [4] = '{8, 8, 8, 8};
  int cyc;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  int n;
  bit seen;

  adc_clk_monitor dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_lost(clr_lost),
    .adc_clk_tgl(tgl), .freq_count(freq_count), .freq_valid(freq_valid),
    .clk_ok(clk_ok), .clk_lost(clk_lost)
  );

  adc_clk_monitor #(.NUM_CH(1), .CNT_W(6)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .clr_lost(clr_lost),
    .adc_clk_tgl(sat_tgl), .freq_count(sat_count), .freq_valid(sat_valid),
    .clk_ok(sat_ok), .clk_lost(sat_lost)
  );

  adc_clk_monitor #(.NUM_CH(1), .LO_LIMIT(130), .HI_LIMIT(120)) dut_cfg (
    .clk(clk), .rst(rst), .enable(enable), .clr_lost(clr_lost),
    .adc_clk_tgl(cfg_tgl), .freq_count(cfg_count), .freq_valid(cfg_valid),
    .clk_ok(cfg_ok), .clk_lost(cfg_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toggle sources, updated on the falling edge with a 50% duty cycle.
  initial begin
    cyc = 0; tgl = 4'b0000; sat_tgl = 1'b0; cfg_tgl = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (per[i] == 0) tgl[i] = 1'b0;
        else             tgl[i] = ((cyc % per[i]) < (per[i] / 2));
      end
      sat_tgl = ((cyc % 4) < 2);
      cfg_tgl = ((cyc % 8) < 4);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Waits for a freq_valid pulse, sampling on falling edges, within a cycle budget.
  task automatic wait_valid(input int budget, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && (cycles < budget)) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (freq_valid === 1'b1) got = 1'b1;
    end
  endtask

  // Channels in zero_ch must read 0, skip_ch are checked by the caller,
  // the rest must hold a nominal period-8 count.
  task automatic check_main(input string tag, input logic [3:0] zero_ch,
                            input logic [3:0] skip_ch, input logic [3:0] exp_ok,
                            input logic [3:0] exp_lost);
    logic [15:0] c;
    for (int i = 0; i < 4; i++) begin
      c = freq_count[i*16 +: 16];
      if (zero_ch[i])
        check_eq($sformatf("%s_ch%0d_cnt", tag, i), 64'(c), 64'd0);
      else if (!skip_ch[i])
        check_eq($sformatf("%s_ch%0d_cnt%0d_in_125_126", tag, i, c),
                 64'((c >= 16'd125) && (c <= 16'd126)), 64'd1);
    end
    check_eq({tag, "_ok"},   64'(clk_ok),   64'(exp_ok));
    check_eq({tag, "_lost"}, 64'(clk_lost), 64'(exp_lost));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr_lost = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_count", freq_count, 64'd0);
    check_eq("rst_valid", 64'(freq_valid), 64'd0);
    check_eq("rst_ok",    64'(clk_ok),     64'd0);
    check_eq("rst_lost",  64'(clk_lost),   64'd0);

    // First window and latency
    rst = 1'b0; enable = 1'b1;
    wait_valid(1200, n, seen);
    check_eq("first_seen", 64'(seen), 64'd1);
    check_eq("first_latency", 64'(n), 64'd1001);
    check_main("nom1", 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    check_eq("sat_count", 64'(sat_count), 64'd63);
    check_eq("sat_ok",    64'(sat_ok),    64'd0);
    check_eq("sat_lost",  64'(sat_lost),  64'd1);
    check_eq("cfg_ok",    64'(cfg_ok),    64'd0);
    check_eq("cfg_lost",  64'(cfg_lost),  64'd1);

    // Window period
    wait_valid(1200, n, seen);
    check_eq("period", 64'(n), 64'd1001);
    check_main("nom2", 4'b0000, 4'b0000, 4'b1111, 4'b0000);

    // Reset in the middle of a window
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_count", freq_count, 64'd0);
    check_eq("midrst_valid", 64'(freq_valid), 64'd0);
    check_eq("midrst_ok",    64'(clk_ok),     64'd0);
    check_eq("midrst_cfg_lost", 64'(cfg_lost), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("midrst_valid_held", 64'(freq_valid), 64'd0);
    rst = 1'b0;
    wait_valid(1200, n, seen);
    check_eq("rerun_latency", 64'(n), 64'd1001);
    check_main("rerun", 4'b0000, 4'b0000, 4'b1111, 4'b0000);

    // Lost clock on channel 2, then recovery and clear
    per[2] = 0;
    wait_valid(1200, n, seen);
    wait_valid(1200, n, seen);
    check_eq("lost_seen", 64'(seen), 64'd1);
    check_main("lost", 4'b0100, 4'b0000, 4'b1011, 4'b0100);
    per[2] = 8;
    wait_valid(1200, n, seen);
    wait_valid(1200, n, seen);
    check_main("resume", 4'b0000, 4'b0000, 4'b1111, 4'b0100);
    repeat (10) @(negedge clk);
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    check_eq("clr_lost", 64'(clk_lost), 64'd0);

    // Channel 1 too fast (period 6)
    per[1] = 6;
    wait_valid(1200, n, seen);
    wait_valid(1200, n, seen);
    check_main("fast", 4'b0000, 4'b0010, 4'b1101, 4'b0010);
    check_eq($sformatf("fast_ch1_cnt%0d_in_165_167", freq_count[31:16]),
             64'((freq_count[31:16] >= 16'd165) && (freq_count[31:16] <= 16'd167)), 64'd1);

    // Clear coinciding with a new fault on channel 0
    per[1] = 8; per[0] = 0;
    wait_valid(1200, n, seen);
    wait_valid(1200, n, seen);
    check_main("simul", 4'b0001, 4'b0000, 4'b1110, 4'b0011);
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    check_eq("simul_lost_after_clr", 64'(clk_lost), 64'd1);

    // Abort mid-window: no result, outputs hold
    per[0] = 8;
    wait_valid(1200, n, seen);
    wait_valid(1200, n, seen);
    check_main("pre_abort", 4'b0000, 4'b0000, 4'b1111, 4'b0001);
    repeat (500) @(negedge clk);
    enable = 1'b0;
    wait_valid(1500, n, seen);
    check_eq("abort_no_valid", 64'(seen), 64'd0);
    check_main("abort_hold", 4'b0000, 4'b0000, 4'b1111, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
